// File: rtl/sm_addsub_pipe_pkg.sv
// sm_pkg: shared types, constants and helpers for the sign-magnitude
// add/sub pipeline.
//   sm_op_t  : default-width operand  {sign, mag[SM_MAG_W-1:0]}
//   sm_res_t : default-width result   {sign, mag[SM_MAG_W:0]}
//   SIGN_POS : sign-bit value meaning "negative"
//   OP_ADD / OP_SUB : encodings of the per-transaction operation select
//   sm_is_zero : zero test on a zero-extended magnitude
package sm_pkg;

  localparam int SM_MAG_W = 32;
  localparam int SM_MAX_W = 128;

  typedef logic [SM_MAG_W:0]   sm_op_t;
  typedef logic [SM_MAG_W+1:0] sm_res_t;

  localparam logic SIGN_POS = 1'b1;
  localparam logic OP_ADD   = 1'b0;
  localparam logic OP_SUB   = 1'b1;

  // Callers zero-extend their magnitude to SM_MAX_W bits.
  function automatic logic sm_is_zero(input logic [SM_MAX_W-1:0] mag);
    return (mag == {SM_MAX_W{1'b0}});
  endfunction

endpackage

// File: rtl/sm_addsub_pipe_mag_cmp.sv
// sm_mag_cmp: combinational magnitude compare and swap.
//   a, b      : unsigned magnitudes
//   big_mag   : max(a, b)
//   small_mag : min(a, b)
//   a_ge_b    : 1 when a >= b (ties resolve toward A)
module sm_mag_cmp #(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] big_mag,
  output logic [W-1:0] small_mag,
  output logic         a_ge_b
);

  // Compare once, then steer both magnitudes from the same decision.
  always_comb begin
    a_ge_b = (a >= b);
    if (a_ge_b) begin
      big_mag   = a;
      small_mag = b;
    end else begin
      big_mag   = b;
      small_mag = a;
    end
  end

endmodule

// File: rtl/sm_addsub_pipe.sv
// sm_addsub_pipe: two-stage pipelined sign-magnitude adder/subtractor with
// valid/ready flow control, optional saturation and a canonical zero.
//   clk, rst (async, active-high), clr (sync flush of in-flight data)
//   in_valid/in_ready, in_a/in_b {sign, mag}, in_sub (1 = A-B), in_tag
//   out_valid/out_ready, out_sum {sign, mag[MAG_W:0]}, out_ovf, out_zero, out_tag
// Latency is 2 cycles when unstalled; up to 2 transactions in flight.
module sm_addsub_pipe
  import sm_pkg::*;
#(
  parameter int MAG_W  = 32,
  parameter bit SAT_EN = 1'b0,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [MAG_W:0]   in_a,
  input  logic [MAG_W:0]   in_b,
  input  logic             in_sub,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [MAG_W+1:0] out_sum,
  output logic             out_ovf,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag
);

  logic             r_s1_valid;
  logic             r_s1_same;
  logic             r_s1_sign;
  logic [MAG_W-1:0] r_s1_big;
  logic [MAG_W-1:0] r_s1_small;
  logic [TAG_W-1:0] r_s1_tag;

  logic             r_out_valid;
  logic [MAG_W+1:0] r_out_sum;
  logic             r_out_ovf;
  logic             r_out_zero;
  logic [TAG_W-1:0] r_out_tag;

  logic             w_adv1;
  logic             w_adv2;
  logic             w_accept;
  logic             w_sign_a;
  logic             w_sign_b;
  logic             w_same;
  logic             w_res_sign;
  logic [MAG_W-1:0] w_big;
  logic [MAG_W-1:0] w_small;
  logic             w_a_ge_b;
  logic [MAG_W:0]   w_mag_full;
  logic [MAG_W:0]   w_mag_res;
  logic             w_mag_zero;
  logic             w_ovf;
  logic             w_sign_out;

  sm_mag_cmp #(.W(MAG_W)) u_mag_cmp (
    .a         (in_a[MAG_W-1:0]),
    .b         (in_b[MAG_W-1:0]),
    .big_mag   (w_big),
    .small_mag (w_small),
    .a_ge_b    (w_a_ge_b)
  );

  // Handshake: a stage advances when its downstream slot is free or draining.
  always_comb begin
    w_adv2   = !r_out_valid | out_ready;
    w_adv1   = !r_s1_valid | w_adv2;
    in_ready = w_adv1 & !clr;
    w_accept = in_valid & in_ready;
  end

  // Stage-1 sign resolution; equal magnitudes keep A's sign.
  always_comb begin
    w_sign_a = in_a[MAG_W];
    w_sign_b = in_b[MAG_W] ^ (in_sub == OP_SUB);
    w_same   = (w_sign_a == w_sign_b);
    if (w_same || w_a_ge_b) begin
      w_res_sign = w_sign_a;
    end else begin
      w_res_sign = w_sign_b;
    end
  end

  // Stage-2 magnitude, saturation and canonical zero (never emit -0).
  always_comb begin
    if (r_s1_same) begin
      w_mag_full = {1'b0, r_s1_big} + {1'b0, r_s1_small};
    end else begin
      w_mag_full = {1'b0, r_s1_big} - {1'b0, r_s1_small};
    end
    if (SAT_EN && w_mag_full[MAG_W]) begin
      w_ovf     = 1'b1;
      w_mag_res = {1'b0, {MAG_W{1'b1}}};
    end else begin
      w_ovf     = 1'b0;
      w_mag_res = w_mag_full;
    end
    w_mag_zero = sm_is_zero(SM_MAX_W'(w_mag_full));
    if (w_mag_zero) begin
      w_sign_out = ~SIGN_POS;
    end else begin
      w_sign_out = r_s1_sign;
    end
  end

  // Stage-1 register: compare/swap results captured on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_same  <= 1'b0;
      r_s1_sign  <= 1'b0;
      r_s1_big   <= {MAG_W{1'b0}};
      r_s1_small <= {MAG_W{1'b0}};
      r_s1_tag   <= {TAG_W{1'b0}};
    end else if (clr) begin
      r_s1_valid <= 1'b0;
    end else if (w_adv1) begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_same  <= w_same;
        r_s1_sign  <= w_res_sign;
        r_s1_big   <= w_big;
        r_s1_small <= w_small;
        r_s1_tag   <= in_tag;
      end
    end
  end

  // Output register: data only changes when a stage-1 entry moves forward,
  // so it stays stable throughout a stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_sum   <= {(MAG_W+2){1'b0}};
      r_out_ovf   <= 1'b0;
      r_out_zero  <= 1'b0;
      r_out_tag   <= {TAG_W{1'b0}};
    end else if (clr) begin
      r_out_valid <= 1'b0;
    end else if (w_adv2) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_sum  <= {w_sign_out, w_mag_res};
        r_out_ovf  <= w_ovf;
        r_out_zero <= w_mag_zero;
        r_out_tag  <= r_s1_tag;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign out_ovf   = r_out_ovf;
  assign out_zero  = r_out_zero;
  assign out_tag   = r_out_tag;

endmodule

// File: tb/tb_sm_addsub_pipe.sv
// Directed bench for sm_addsub_pipe: one full-precision and one saturating
// instance driven with the same stimulus.
module tb_sm_addsub_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready, in_ready_s;
  logic [32:0] in_a = 33'h0;
  logic [32:0] in_b = 33'h0;
  logic        in_sub = 1'b0;
  logic [3:0]  in_tag = 4'h0;
  logic        out_ready = 1'b1;
  logic        out_valid, out_valid_s;
  logic [33:0] out_sum, out_sum_s;
  logic        out_ovf, out_ovf_s;
  logic        out_zero, out_zero_s;
  logic [3:0]  out_tag, out_tag_s;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int next_tag;
  int exp_tag;

  always #5 clk = ~clk;

  sm_addsub_pipe #(.MAG_W(32), .SAT_EN(1'b0), .TAG_W(4)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_ovf(out_ovf), .out_zero(out_zero), .out_tag(out_tag)
  );

  sm_addsub_pipe #(.MAG_W(32), .SAT_EN(1'b1), .TAG_W(4)) dut_sat (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready_s),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_tag(in_tag),
    .out_valid(out_valid_s), .out_ready(out_ready),
    .out_sum(out_sum_s), .out_ovf(out_ovf_s), .out_zero(out_zero_s), .out_tag(out_tag_s)
  );

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // One isolated transaction with out_ready=1 on an empty pipeline.
  task automatic run_one(input string name, input logic [32:0] a, input logic [32:0] b,
                         input logic sub, input logic [3:0] tag,
                         input logic [33:0] exp_sum, input logic exp_zero,
                         input logic [33:0] exp_sum_sat, input logic exp_ovf_sat);
    @(negedge clk);
    in_a = a; in_b = b; in_sub = sub; in_tag = tag; in_valid = 1'b1;
    #1 chk({name, "_in_ready"}, in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk({name, "_lat1_valid"}, out_valid, 1'b0);
    @(negedge clk);
    #1;
    chk({name, "_valid"}, out_valid, 1'b1);
    chk({name, "_sum"}, out_sum, exp_sum);
    chk({name, "_zero"}, out_zero, exp_zero);
    chk({name, "_ovf"}, out_ovf, 1'b0);
    chk({name, "_tag"}, out_tag, tag);
    chk({name, "_sat_sum"}, out_sum_s, exp_sum_sat);
    chk({name, "_sat_ovf"}, out_ovf_s, exp_ovf_sat);
  endtask

  // Load two transactions and stall them (out_ready=0) so both stages are full.
  task automatic fill_two();
    out_ready = 1'b0;
    @(negedge clk);
    in_a = 33'h0_0000_0011; in_b = 33'h0; in_sub = 1'b0; in_tag = 4'hA; in_valid = 1'b1;
    @(negedge clk);
    in_tag = 4'hB;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    #2;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_sum", out_sum, 34'h0);
    chk("rst_out_tag", out_tag, 4'h0);
    chk("rst_out_zero", out_zero, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("post_rst_in_ready", in_ready, 1'b1);

    run_one("neg_plus_pos", 33'h1_0000_1234, 33'h0_0000_0123, 1'b0, 4'h1,
            34'h2_0000_1111, 1'b0, 34'h2_0000_1111, 1'b0);
    run_one("max_add", 33'h0_FFFF_FFFF, 33'h0_FFFF_FFFF, 1'b0, 4'h2,
            34'h1_FFFF_FFFE, 1'b0, 34'h0_FFFF_FFFF, 1'b1);
    run_one("3_sub_10", 33'h0_0000_0003, 33'h0_0000_000A, 1'b1, 4'h3,
            34'h2_0000_0007, 1'b0, 34'h2_0000_0007, 1'b0);
    run_one("m5_sub_m5", 33'h1_0000_0005, 33'h1_0000_0005, 1'b1, 4'h4,
            34'h0, 1'b1, 34'h0, 1'b0);
    run_one("p0_add_m0", 33'h0_0000_0000, 33'h1_0000_0000, 1'b0, 4'h5,
            34'h0, 1'b1, 34'h0, 1'b0);
    run_one("neg_max_sub", 33'h1_FFFF_FFFF, 33'h0_0000_0002, 1'b1, 4'h6,
            34'h3_0000_0001, 1'b0, 34'h2_FFFF_FFFF, 1'b1);

    // Backpressure: tags 1..4 back to back, out_ready held low for 5 cycles.
    next_tag = 1;
    exp_tag  = 1;
    for (int cyc = 0; cyc < 40 && exp_tag <= 4; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 5);
      in_valid  = (next_tag <= 4);
      in_tag    = 4'(next_tag);
      in_a      = 33'(next_tag);
      in_b      = 33'h0;
      in_sub    = 1'b0;
      #1;
      if (cyc >= 2 && cyc < 5) begin
        chk("bp_in_ready_low", in_ready, 1'b0);
        chk("bp_out_valid", out_valid, 1'b1);
        chk("bp_tag_stable", out_tag, 4'h1);
        chk("bp_sum_stable", out_sum, 34'h1);
      end
      if (out_valid && out_ready) begin
        chk("bp_order_tag", out_tag, 4'(exp_tag));
        chk("bp_order_sum", out_sum, 34'(exp_tag));
        exp_tag++;
      end
      if (in_valid && in_ready) next_tag++;
    end
    chk("bp_all_drained", 64'(exp_tag), 64'd5);
    in_valid = 1'b0;
    @(negedge clk);
    #1 chk("bp_no_dup", out_valid, 1'b0);

    // Asynchronous reset with two transactions in flight.
    fill_two();
    #1 chk("rst_pre_valid", out_valid, 1'b1);
    rst = 1'b1;
    #1;
    chk("rst_async_valid", out_valid, 1'b0);
    chk("rst_async_sum", out_sum, 34'h0);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1 chk("rst_no_stale", out_valid, 1'b0);
    end
    run_one("after_rst", 33'h0_0000_0010, 33'h0_0000_0004, 1'b1, 4'h7,
            34'h0_0000_000C, 1'b0, 34'h0_0000_000C, 1'b0);

    // clr with two in flight and a simultaneous input.
    fill_two();
    @(negedge clk);
    clr = 1'b1; in_valid = 1'b1; in_tag = 4'h9;
    #1 chk("clr_in_ready", in_ready, 1'b0);
    @(negedge clk);
    clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1 chk("clr_flush_valid", out_valid, 1'b0);
    @(negedge clk);
    #1 chk("clr_not_accepted", out_valid, 1'b0);
    run_one("after_clr", 33'h1_0000_0008, 33'h0_0000_0003, 1'b1, 4'hC,
            34'h2_0000_000B, 1'b0, 34'h2_0000_000B, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
